// File: rtl/pll_reset_seq.sv
// Power-up and recovery sequencer for the main clock PLL: pulses the PLL reset, qualifies lock,
// then releases the SDRAM-controller reset and, after a delay, the core reset.
module pll_reset_seq #(
    parameter int RST_PULSE    = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int SDRAM_DELAY  = 256,
    parameter int CNT_W        = 17
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic       sdram_rst_n,
    output logic       core_rst_n,
    output logic       ready,
    output logic       lock_lost,
    output logic [3:0] retry_count
);

    typedef enum logic [2:0] {
        ST_PLLRST   = 3'd0,
        ST_WAITLOCK = 3'd1,
        ST_STABLE   = 3'd2,
        ST_SDRAM    = 3'd3,
        ST_RUN      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_RST_LAST     = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_SDRAM_LAST   = CNT_W'(SDRAM_DELAY - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sync1;
    logic             r_locked_s;
    logic             r_pll_rst;
    logic             r_sdram_rst_n;
    logic             r_core_rst_n;
    logic             r_ready;
    logic             r_lock_lost;
    logic [3:0]       r_retry_count;

    state_t           w_next;
    logic             w_cnt_clr;
    logic             w_lost;
    logic             w_retry_inc;
    logic [CNT_W-1:0] w_cnt_next;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Next-state decision; soft_reset outranks lock loss, so a coincident drop raises no lock_lost.
    always_comb begin
        w_next      = r_state;
        w_cnt_clr   = 1'b0;
        w_lost      = 1'b0;
        w_retry_inc = 1'b0;
        if (soft_reset) begin
            w_next    = ST_PLLRST;
            w_cnt_clr = 1'b1;
        end else begin
            case (r_state)
                ST_PLLRST: begin
                    if (r_cnt == C_RST_LAST) w_next = ST_WAITLOCK;
                end
                ST_WAITLOCK: begin
                    if (r_locked_s) begin
                        w_next = ST_STABLE;
                    end else if (r_cnt == C_TIMEOUT_LAST) begin
                        w_next      = ST_PLLRST;
                        w_retry_inc = 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!r_locked_s)                  w_next = ST_WAITLOCK;
                    else if (r_cnt == C_STABLE_LAST)  w_next = ST_SDRAM;
                end
                ST_SDRAM: begin
                    if (!r_locked_s) begin
                        w_next = ST_PLLRST;
                        w_lost = 1'b1;
                    end else if (r_cnt == C_SDRAM_LAST) begin
                        w_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!r_locked_s) begin
                        w_next = ST_PLLRST;
                        w_lost = 1'b1;
                    end
                end
                default: w_next = ST_PLLRST;
            endcase
        end
    end

    // The counter is idle in RUN so it never wraps while the core is running.
    always_comb begin
        w_cnt_next = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        if (w_cnt_clr || (w_next != r_state)) w_cnt_next = '0;
        else if (r_state == ST_RUN)           w_cnt_next = r_cnt;
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_state       <= ST_PLLRST;
            r_cnt         <= '0;
            r_sync1       <= 1'b0;
            r_locked_s    <= 1'b0;
            r_pll_rst     <= 1'b1;
            r_sdram_rst_n <= 1'b0;
            r_core_rst_n  <= 1'b0;
            r_ready       <= 1'b0;
            r_lock_lost   <= 1'b0;
            r_retry_count <= 4'd0;
        end else begin
            r_sync1       <= pll_locked;
            r_locked_s    <= r_sync1;
            r_state       <= w_next;
            r_cnt         <= w_cnt_next;
            r_pll_rst     <= (w_next == ST_PLLRST);
            r_sdram_rst_n <= (w_next == ST_SDRAM) || (w_next == ST_RUN);
            r_core_rst_n  <= (w_next == ST_RUN);
            r_ready       <= (w_next == ST_RUN);
            r_lock_lost   <= w_lost;
            if (w_retry_inc) r_retry_count <= sat_inc4(r_retry_count);
        end
    end

    assign pll_rst     = r_pll_rst;
    assign sdram_rst_n = r_sdram_rst_n;
    assign core_rst_n  = r_core_rst_n;
    assign ready       = r_ready;
    assign lock_lost   = r_lock_lost;
    assign retry_count = r_retry_count;

endmodule
